// File: rtl/vgafb_scanout.sv
// VGA scan-out: raster timing from programmable counters, pops RGB565 pixels and drives registered RGB888/sync/blank.
// Outputs change one sys_clk after each pixel slot; a starved active slot shows black and bumps underflows.
module vgafb_scanout #(
  parameter int CLKDIV = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [10:0] hres,
  input  logic [10:0] hsync_start,
  input  logic [10:0] hsync_end,
  input  logic [10:0] hscan,
  input  logic [10:0] vres,
  input  logic [10:0] vsync_start,
  input  logic [10:0] vsync_end,
  input  logic [10:0] vscan,
  input  logic        pixel_valid,
  input  logic [15:0] pixel,
  output logic        pixel_ack,
  output logic        vga_hsync_n,
  output logic        vga_vsync_n,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic [15:0] underflows
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] r_div;
  logic [10:0]   r_h, r_v;
  logic          r_first;
  logic [10:0]   r_hres, r_hss, r_hse, r_hscan;
  logic [10:0]   r_vres, r_vss, r_vse, r_vscan;
  logic          r_hsync_n, r_vsync_n, r_blank_n, r_frame_start;
  logic [23:0]   r_rgb;
  logic [15:0]   r_underflows;

  // Until the first slot after enable rises, the live inputs stand in for the shadows
  // so the very first frame already uses the programmed timing.
  logic [10:0] w_hres, w_hss, w_hse, w_hscan, w_vres, w_vss, w_vse, w_vscan;
  assign w_hres  = r_first ? hres        : r_hres;
  assign w_hss   = r_first ? hsync_start : r_hss;
  assign w_hse   = r_first ? hsync_end   : r_hse;
  assign w_hscan = r_first ? hscan       : r_hscan;
  assign w_vres  = r_first ? vres        : r_vres;
  assign w_vss   = r_first ? vsync_start : r_vss;
  assign w_vse   = r_first ? vsync_end   : r_vse;
  assign w_vscan = r_first ? vscan       : r_vscan;

  logic w_pce, w_hwrap, w_vwrap, w_fwrap, w_in_area, w_active, w_load;
  assign w_pce     = enable && (r_div == DIV_LAST);
  assign w_hwrap   = (r_h == w_hscan);
  assign w_vwrap   = (r_v == w_vscan);
  assign w_fwrap   = w_hwrap && w_vwrap;
  assign w_in_area = (r_h < w_hres) && (r_v < w_vres);
  assign w_active  = w_pce && w_in_area;
  assign w_load    = w_pce && (r_first || w_fwrap);
  assign pixel_ack = w_active && pixel_valid;

  logic [23:0] w_rgb888;
  assign w_rgb888 = {pixel[15:11], pixel[15:13],
                     pixel[10:5],  pixel[10:9],
                     pixel[4:0],   pixel[4:2]};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_first       <= 1'b1;
      r_hres        <= '0;
      r_hss         <= '0;
      r_hse         <= '0;
      r_hscan       <= '0;
      r_vres        <= '0;
      r_vss         <= '0;
      r_vse         <= '0;
      r_vscan       <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_underflows  <= '0;
    end else if (!enable) begin
      // Idle: park the raster at (0,0) and blank; the underflow count is kept.
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_first       <= 1'b1;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_pce ? '0 : r_div + 1'b1;
      r_frame_start <= w_load;
      if (w_pce) begin
        r_first   <= 1'b0;
        r_hsync_n <= !((r_h >= w_hss) && (r_h < w_hse));
        r_vsync_n <= !((r_v >= w_vss) && (r_v < w_vse));
        r_blank_n <= w_in_area;
        r_rgb     <= (w_in_area && pixel_valid) ? w_rgb888 : 24'h0;
        if (w_in_area && !pixel_valid && (r_underflows != 16'hFFFF))
          r_underflows <= r_underflows + 16'd1;
        if (w_hwrap) begin
          r_h <= '0;
          r_v <= w_vwrap ? 11'd0 : r_v + 11'd1;
        end else begin
          r_h <= r_h + 11'd1;
        end
        if (w_load) begin
          r_hres  <= hres;
          r_hss   <= hsync_start;
          r_hse   <= hsync_end;
          r_hscan <= hscan;
          r_vres  <= vres;
          r_vss   <= vsync_start;
          r_vse   <= vsync_end;
          r_vscan <= vscan;
        end
      end
    end
  end

  assign vga_hsync_n = r_hsync_n;
  assign vga_vsync_n = r_vsync_n;
  assign vga_blank_n = r_blank_n;
  assign vga_r       = r_rgb[23:16];
  assign vga_g       = r_rgb[15:8];
  assign vga_b       = r_rgb[7:0];
  assign frame_start = r_frame_start;
  assign underflows  = r_underflows;

endmodule

// File: tb/tb_vgafb_scanout.sv
// Bench for vgafb_scanout: random pixels/valid/enable/timing against a frame-position model,
// plus a CLKDIV=1 instance driven starved to reach underflow saturation.
module tb_vgafb_scanout;

  localparam int CLKDIV = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] hres = 11'd4, hsync_start = 11'd5, hsync_end = 11'd7, hscan = 11'd7;
  logic [10:0] vres = 11'd2, vsync_start = 11'd3, vsync_end = 11'd4, vscan = 11'd4;
  logic        pixel_valid = 1'b0;
  logic [15:0] pixel = 16'h0;

  logic        pixel_ack, vga_hsync_n, vga_vsync_n, vga_blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [15:0] underflows;

  logic        sat_en = 1'b0;
  logic        s_ack, s_hs, s_vs, s_bl, s_fs;
  logic [7:0]  s_r, s_g, s_b;
  logic [15:0] s_uf;

  always #5 sys_clk = ~sys_clk;

  vgafb_scanout #(.CLKDIV(CLKDIV)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
    .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
    .pixel_valid(pixel_valid), .pixel(pixel), .pixel_ack(pixel_ack),
    .vga_hsync_n(vga_hsync_n), .vga_vsync_n(vga_vsync_n), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .underflows(underflows)
  );

  // Every slot of this raster is active and no pixel is ever offered.
  vgafb_scanout #(.CLKDIV(1)) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(sat_en),
    .hres(11'd2047), .hsync_start(11'd0), .hsync_end(11'd0), .hscan(11'd15),
    .vres(11'd2047), .vsync_start(11'd0), .vsync_end(11'd0), .vscan(11'd3),
    .pixel_valid(1'b0), .pixel(16'h0), .pixel_ack(s_ack),
    .vga_hsync_n(s_hs), .vga_vsync_n(s_vs), .vga_blank_n(s_bl),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .frame_start(s_fs), .underflows(s_uf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int hres, hss, hse, hscan, vres, vss, vse, vscan;
  } tim_t;

  tim_t m_snap = '{0, 0, 0, 0, 0, 0, 0, 0};
  int   m_cyc = 0;     // enabled cycles since the raster was last parked
  int   m_pos = 0;     // slot index within the current frame
  bit   m_fresh = 1'b1;
  logic e_hs = 1'b1, e_vs = 1'b1, e_bl = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = 24'h0;
  int   e_uf = 0;
  int   e_sat = 0;

  function automatic tim_t live();
    tim_t t;
    t.hres = hres; t.hss = hsync_start; t.hse = hsync_end; t.hscan = hscan;
    t.vres = vres; t.vss = vsync_start; t.vse = vsync_end; t.vscan = vscan;
    return t;
  endfunction

  function automatic tim_t eff();
    return m_fresh ? live() : m_snap;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic bit slot_active(input tim_t t, input int pos);
    int h, v;
    h = pos % (t.hscan + 1);
    v = pos / (t.hscan + 1);
    return (h < t.hres) && (v < t.vres);
  endfunction

  tim_t mt;
  int   mh, mv, mlen;
  bit   mact, mpce;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_snap = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_cyc = 0; m_pos = 0; m_fresh = 1'b1;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      e_uf = 0; e_sat = 0;
    end else begin
      if (sat_en && e_sat < 65535) e_sat++;
      if (!enable) begin
        m_cyc = 0; m_pos = 0; m_fresh = 1'b1;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      end else begin
        mt   = eff();
        mpce = (m_cyc % CLKDIV) == CLKDIV - 1;
        m_cyc++;
        e_fs = 1'b0;
        if (mpce) begin
          mlen = (mt.hscan + 1) * (mt.vscan + 1);
          mh   = m_pos % (mt.hscan + 1);
          mv   = m_pos / (mt.hscan + 1);
          mact = slot_active(mt, m_pos);
          e_hs = !(mh >= mt.hss && mh < mt.hse);
          e_vs = !(mv >= mt.vss && mv < mt.vse);
          e_bl = mact;
          e_rgb = (mact && pixel_valid) ? expand(pixel) : 24'h0;
          if (mact && !pixel_valid && e_uf < 65535) e_uf++;
          e_fs = m_fresh || (m_pos == mlen - 1);
          if (e_fs) m_snap = live();
          m_fresh = 1'b0;
          m_pos = (m_pos + 1) % mlen;
        end
      end
    end
  end

  tim_t ct;
  bit   c_ack;

  always @(negedge sys_clk) begin
    ct = eff();
    c_ack = enable && ((m_cyc % CLKDIV) == CLKDIV - 1) && slot_active(ct, m_pos) && pixel_valid;
    chk("video", {19'h0, pixel_ack, vga_hsync_n, vga_vsync_n, vga_blank_n, frame_start, vga_r, vga_g, vga_b},
                 {19'h0, c_ack, e_hs, e_vs, e_bl, e_fs, e_rgb});
    chk("underflows", {32'h0, underflows}, 48'(e_uf));
    chk("sat_dut", {31'h0, s_ack, s_uf}, {31'h0, 1'b0, 16'(e_sat)});
  end

  // ---------------- stimulus ----------------
  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  task automatic run(input int n, input int pv_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      case ($urandom_range(3))
        0: pixel = 16'hF800;
        1: pixel = 16'h07E0;
        2: pixel = 16'h001F;
        default: pixel = 16'($urandom);
      endcase
      pixel_valid = ($urandom_range(99) < pv_pct);
    end
  endtask

  task automatic set_timing(input int hr, input int hs, input int he, input int hc,
                            input int vr, input int vs, input int ve, input int vc);
    hres = 11'(hr); hsync_start = 11'(hs); hsync_end = 11'(he); hscan = 11'(hc);
    vres = 11'(vr); vsync_start = 11'(vs); vsync_end = 11'(ve); vscan = 11'(vc);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    enable = 1'b1;
    sat_en = 1'b1;

    run(240, 100);                       // baseline raster, always fed
    run(200, 60);                        // intermittent starvation
    run(6, 0);                           // consecutive starved slots
    run(100, 100);
    run(37, 100);
    hres = 11'd2;                        // takes effect at the next frame
    run(200, 100);
    run(13, 100);
    enable = 1'b0;
    run(10, 100);
    enable = 1'b1;
    run(100, 100);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(2) == 0)
        set_timing($urandom_range(12), $urandom_range(12), $urandom_range(12), $urandom_range(9),
                   $urandom_range(7),  $urandom_range(7),  $urandom_range(7),  $urandom_range(5));
      if ($urandom_range(5) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 12), 80);
        enable = 1'b1;
      end
      run($urandom_range(20, 150), $urandom_range(100));
    end

    set_timing(4, 5, 7, 7, 2, 3, 4, 4);
    while (cyc < 66200) run(200, 85);

    chk("sat_peak", {32'h0, s_uf}, {32'h0, 16'hFFFF});

    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    #1;
    chk("arst_video", {19'h0, pixel_ack, vga_hsync_n, vga_vsync_n, vga_blank_n, frame_start, vga_r, vga_g, vga_b},
                      {19'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    chk("arst_uf", {32'h0, underflows}, 48'h0);
    chk("arst_sat_uf", {32'h0, s_uf}, 48'h0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    run(150, 90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
